// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg / mem_stage_if
//
// Purpose:
//   mem_stage_pkg holds the pipeline bundles that enter and leave the memory
//   stage. mem_stage_if groups the valid/grant data-memory bus.
//
// mem_stage_if signals:
//   req     master->slave  bus request
//   we      master->slave  1 = store, 0 = load
//   addr    master->slave  32-bit word address
//   wdata   master->slave  32-bit store data
//   gnt     slave->master  request accepted this cycle
//   rvalid  slave->master  load data valid this cycle
//   rdata   slave->master  32-bit load data
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic [4:0]  rd;
  } ex_to_mem_s;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_to_wb_s;

  // An all-zero write-back bundle never writes the register file.
  localparam mem_to_wb_s WB_BUBBLE = '0;

endpackage

interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Purpose:
//   Memory-access stage of the five-stage RV32I pipeline. Issues word loads
//   and stores on the data-memory bus, stalls upstream while a transaction is
//   outstanding and registers the write-back bundle.
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst            asynchronous reset, active-high
//   ex_to_mem_i    registered bundle from execute (stable while stalled)
//   mem_to_wb_o    registered bundle to write-back
//   stall_o        combinational; upstream holds its registers while high
//   dmem           data-memory bus (mem_stage_if.master)
//   misalign_o     registered one-cycle misaligned-access pulse
//   stall_count_o  saturating count of stalled cycles
//
// Build option:
//   MEM_STAGE_ALIGN_CHECK_EN  when defined, accesses with alu_result[1:0] != 0
//                             are dropped (bubble + misalign pulse). When not
//                             defined, the low address bits are cleared and
//                             the access proceeds; misalign_o is tied to 0.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  ex_to_mem_s         ex_to_mem_i,
  output mem_to_wb_s         mem_to_wb_o,
  output logic               stall_o,
  mem_stage_if.master        dmem,
  output logic               misalign_o,
  output logic [31:0]        stall_count_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    WAIT_R = 1'b1
  } state_e;

  state_e      state_q, state_d;
  mem_to_wb_s  mem_to_wb_q, mem_to_wb_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        req;
  logic        stall;
  logic        access;
  logic        is_store;
  logic        misaligned;
  mem_to_wb_s  wb_pass;

  assign access   = ex_to_mem_i.mem_read | ex_to_mem_i.mem_write;
  // A request with both flags set is treated as a store.
  assign is_store = ex_to_mem_i.mem_write;

  assign wb_pass.result    = ex_to_mem_i.alu_result;
  assign wb_pass.rd        = ex_to_mem_i.rd;
  assign wb_pass.reg_write = ex_to_mem_i.reg_write;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misaligned = access && (ex_to_mem_i.alu_result[1:0] != 2'b00);
  // Misaligned accesses are never issued, so the address needs no masking.
  assign dmem.addr  = ex_to_mem_i.alu_result;
`else
  assign misaligned = 1'b0;
  assign dmem.addr  = {ex_to_mem_i.alu_result[31:2], 2'b00};
`endif

  assign dmem.we    = is_store;
  assign dmem.wdata = ex_to_mem_i.write_data;
  assign dmem.req   = req;
  assign stall_o    = stall;

  // NOTE: every signal written below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mem_to_wb_d = WB_BUBBLE;
    req         = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!access) begin
          mem_to_wb_d = wb_pass;
        end else if (!misaligned) begin
          req = 1'b1;
          if (dmem.gnt) begin
            if (is_store) begin
              mem_to_wb_d = wb_pass;
            end else begin
              state_d = WAIT_R;
              stall   = 1'b1;
            end
          end else begin
            // Request stays up; address/data hold because upstream is frozen.
            stall = 1'b1;
          end
        end
        // A dropped misaligned access leaves the bubble and no stall.
      end

      WAIT_R: begin
        // rd/reg_write still come from ex_to_mem_i, which is held by the stall.
        if (dmem.rvalid) begin
          mem_to_wb_d.result    = dmem.rdata;
          mem_to_wb_d.rd        = ex_to_mem_i.rd;
          mem_to_wb_d.reg_write = ex_to_mem_i.reg_write;
          state_d               = IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign stall_count_d = (stall && (stall_count_q != 32'hFFFF_FFFF))
                       ? stall_count_q + 32'd1
                       : stall_count_q;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_to_wb_q   <= WB_BUBBLE;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_to_wb_q   <= mem_to_wb_d;
      stall_count_q <= stall_count_d;
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misaligned;
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign mem_to_wb_o   = mem_to_wb_q;
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage. A transaction-level model predicts, for
// each operation, how many cycles stall stays high (grant delay, plus the
// read latency for loads), what the bus shows while requesting, and which
// bundle reaches write-back. Bus inputs that the stage must ignore are
// randomised.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef enum int {OP_NONE, OP_STORE, OP_LOAD, OP_BOTH} op_e;

  logic        clk = 1'b0;
  logic        rst;
  ex_to_mem_s  ex;
  mem_to_wb_s  wb;
  logic        stall;
  logic        misalign;
  logic [31:0] stall_count;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] sc_model = '0;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_to_mem_i   (ex),
    .mem_to_wb_o   (wb),
    .stall_o       (stall),
    .dmem          (dmem.master),
    .misalign_o    (misalign),
    .stall_count_o (stall_count)
  );

  always #5 clk = ~clk;

  function automatic mem_to_wb_s mk_wb(input logic [31:0] res, input logic [4:0] rd,
                                       input logic rw);
    mem_to_wb_s w;
    w.result    = res;
    w.rd        = rd;
    w.reg_write = rw;
    return w;
  endfunction

  // Drives one operation from issue to completion. Entered shortly after a
  // rising edge; returns shortly after the edge that completes it.
  task automatic run_op(input string name, input op_e op, input logic [31:0] alu,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [4:0] rd, input logic rw, input int g, input int r);
    bit          acc, ld, st, exp_req, exp_stall;
    int          total;
    mem_to_wb_s  final_wb, exp_wb;
    logic [31:0] exp_addr;
    acc      = (op != OP_NONE);
    ld       = (op == OP_LOAD);
    st       = (op == OP_STORE) || (op == OP_BOTH);
    total    = !acc ? 0 : (ld ? g + r : g);
    final_wb = ld ? mk_wb(rdata, rd, rw) : mk_wb(alu, rd, rw);
    exp_addr = alu & 32'hFFFF_FFFC;

    ex.alu_result = alu;
    ex.write_data = wdata;
    ex.mem_read   = (op == OP_LOAD) || (op == OP_BOTH);
    ex.mem_write  = st;
    ex.rd         = rd;
    ex.reg_write  = rw;

    for (int c = 0; c <= total; c++) begin
      exp_req   = acc && (c <= g);
      exp_stall = (c < total);
      dmem.gnt    = (acc && c == g) ? 1'b1 : (exp_req ? 1'b0 : 1'($urandom_range(0, 1)));
      dmem.rvalid = (ld && c == total) ? 1'b1
                  : ((ld && c > g) ? 1'b0 : 1'($urandom_range(0, 1)));
      dmem.rdata  = (ld && c == total) ? rdata : $urandom;
      #1;
      total_cnt++;
      if (stall !== exp_stall)
        $display("FAIL %s stall c=%0d: got %b want %b", name, c, stall, exp_stall);
      else pass_cnt++;
      total_cnt++;
      if (dmem.req !== exp_req)
        $display("FAIL %s req c=%0d: got %b want %b", name, c, dmem.req, exp_req);
      else pass_cnt++;
      if (exp_req) begin
        total_cnt++;
        if ({dmem.addr, dmem.we, dmem.wdata} !== {exp_addr, st, wdata})
          $display("FAIL %s bus c=%0d: got %h/%b/%h want %h/%b/%h", name, c,
                   dmem.addr, dmem.we, dmem.wdata, exp_addr, st, wdata);
        else pass_cnt++;
      end
      @(posedge clk);
      if (exp_stall) sc_model++;
      #1;
      exp_wb = (c == total) ? final_wb : WB_BUBBLE;
      total_cnt++;
      if (wb !== exp_wb)
        $display("FAIL %s wb c=%0d: got %h want %h", name, c, wb, exp_wb);
      else pass_cnt++;
      total_cnt++;
      if (misalign !== 1'b0)
        $display("FAIL %s misalign c=%0d: got %b want 0", name, c, misalign);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_count !== sc_model)
      $display("FAIL %s stall_count: got %0d want %0d", name, stall_count, sc_model);
    else pass_cnt++;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex  = '0;
    ex.mem_read   = 1'b1;
    ex.alu_result = 32'h40;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = '0;
    #12;
    total_cnt++;
    if (wb !== WB_BUBBLE) $display("FAIL reset wb: got %h want 0", wb); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 32'd0) $display("FAIL reset stall_count: got %0d want 0", stall_count);
    else pass_cnt++;
    total_cnt++;
    if (misalign !== 1'b0) $display("FAIL reset misalign: got %b want 0", misalign);
    else pass_cnt++;
    // IDLE with a pending load and no grant: request up, stalled.
    total_cnt++;
    if ({dmem.req, stall} !== 2'b11)
      $display("FAIL reset idle_req: got req=%b stall=%b want 1/1", dmem.req, stall);
    else pass_cnt++;
    ex = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sc_model = '0;
  endtask

  task automatic test_alu();
    run_op("alu", OP_NONE, 32'h10, 32'h0, 32'h0, 5'd5, 1'b1, 0, 0);
  endtask

  task automatic test_store();
    run_op("store", OP_STORE, 32'h100, 32'hDEAD_BEEF, 32'h0, 5'd2, 1'b0, 0, 0);
  endtask

  task automatic test_load();
    run_op("load", OP_LOAD, 32'h200, 32'h0, 32'h1234_5678, 5'd7, 1'b1, 2, 3);
    total_cnt++;
    if (stall_count !== 32'd5) $display("FAIL load stall_count: got %0d want 5", stall_count);
    else pass_cnt++;
  endtask

  task automatic test_both_flags();
    run_op("both", OP_BOTH, 32'h44, 32'h0BAD_F00D, 32'h0, 5'd11, 1'b1, 1, 0);
  endtask

  task automatic test_misalign();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ex = '0;
    ex.mem_read   = 1'b1;
    ex.alu_result = 32'h202;
    ex.rd         = 5'd7;
    ex.reg_write  = 1'b1;
    dmem.gnt      = 1'b1;
    #1;
    total_cnt++;
    if ({dmem.req, stall} !== 2'b00)
      $display("FAIL misalign issue: got req=%b stall=%b want 0/0", dmem.req, stall);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({wb, misalign} !== {WB_BUBBLE, 1'b1})
      $display("FAIL misalign pulse: got wb=%h mis=%b want 0/1", wb, misalign);
    else pass_cnt++;
    ex       = '0;
    dmem.gnt = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (misalign !== 1'b0) $display("FAIL misalign width: got %b want 0", misalign);
    else pass_cnt++;
`else
    run_op("misalign", OP_LOAD, 32'h202, 32'h0, 32'hA5A5_5A5A, 5'd7, 1'b1, 0, 1);
`endif
  endtask

  task automatic test_reset_wait_r();
    ex = '0;
    ex.mem_read   = 1'b1;
    ex.alu_result = 32'h300;
    ex.rd         = 5'd9;
    ex.reg_write  = 1'b1;
    dmem.gnt      = 1'b1;
    #1;
    @(posedge clk);
    #1;
    dmem.gnt = 1'b0;
    #1;
    total_cnt++;
    if ({dmem.req, stall} !== 2'b01)
      $display("FAIL rst_wait in_wait_r: got req=%b stall=%b want 0/1", dmem.req, stall);
    else pass_cnt++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({wb, stall_count} !== {WB_BUBBLE, 32'd0})
      $display("FAIL rst_wait regs: got wb=%h sc=%0d want 0/0", wb, stall_count);
    else pass_cnt++;
    total_cnt++;
    if (dmem.req !== 1'b1)
      $display("FAIL rst_wait back_to_idle: got req=%b want 1", dmem.req);
    else pass_cnt++;
    rst      = 1'b0;
    sc_model = '0;
    ex = '0;
    ex.alu_result = 32'h55;
    ex.rd         = 5'd3;
    ex.reg_write  = 1'b1;
    dmem.rvalid   = 1'b1;
    dmem.rdata    = 32'hCAFE_F00D;
    #1;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL rst_wait stall: got %b want 0", stall); else pass_cnt++;
    @(posedge clk);
    #1;
    dmem.rvalid = 1'b0;
    total_cnt++;
    if (wb !== mk_wb(32'h55, 5'd3, 1'b1))
      $display("FAIL rst_wait late_data: got %h want %h", wb, mk_wb(32'h55, 5'd3, 1'b1));
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== 32'd0)
      $display("FAIL rst_wait stall_count: got %0d want 0", stall_count);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      op_e         op;
      logic [31:0] alu;
      op  = op_e'($urandom_range(0, 3));
      alu = $urandom;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      if (op != OP_NONE) alu[1:0] = 2'b00;
`endif
      run_op($sformatf("rand%0d", i), op, alu, $urandom, $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_both_flags();
    test_misalign();
    test_reset_wait_r();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
